// File: rtl/nanov_regfile_pkg.sv
// Shared defaults and digit-count helpers for the bit/digit-serial register file.
package nanov_regfile_pkg;

   localparam int DEF_XLEN          = 32;
   localparam int DEF_NUM_REGS      = 16;
   localparam int DEF_REG_ADDR_BITS = 4;
   localparam int DEF_DIGIT         = 1;

   // Number of digits that make up one word.
   function automatic int num_digits(input int xlen, input int digit);
      return xlen / digit;
   endfunction

   // Width of the digit index; at least one bit so a one-digit word still has a port.
   function automatic int idx_bits(input int xlen, input int digit);
      return (xlen / digit <= 1) ? 1 : $clog2(xlen / digit);
   endfunction

endpackage

// File: rtl/nanov_serial_reg.sv
// One rotating register: shifts right by DIGIT per enabled clock, the digit
// re-entering at the top is either the old low digit or the write digit.
module nanov_serial_reg #(
   parameter int XLEN  = 32,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             wr,
   input  logic [DIGIT-1:0] wdig,
   output logic [DIGIT-1:0] q
);

   logic [XLEN-1:0]  r;
   logic [DIGIT-1:0] top;

   assign top = wr ? wdig : r[DIGIT-1:0];
   assign q   = r[DIGIT-1:0];

   generate
      if (XLEN == DIGIT) begin : g_one
         // Single-digit word: the whole register is replaced or kept.
         always_ff @(posedge clk or posedge rst) begin
            if (rst)     r <= '0;
            else if (en) r <= top;
         end
      end else begin : g_rot
         // Rotate right one digit, inserting the selected digit at the top.
         always_ff @(posedge clk or posedge rst) begin
            if (rst)     r <= '0;
            else if (en) r <= {top, r[XLEN-1:DIGIT]};
         end
      end
   endgenerate

endmodule

// File: rtl/nanov_serial_regfile.sv
// Digit-serial register file: NUM_REGS-1 rotating registers (x0 reads zero),
// a shared digit counter and NUM_RD combinational read muxes.
// Optional macro REGFILE_BYPASS_EN forwards the write digit to a read port
// addressing the register being written in the same cycle.
module nanov_serial_regfile
   import nanov_regfile_pkg::*;
#(
   parameter int XLEN          = DEF_XLEN,
   parameter int NUM_REGS      = DEF_NUM_REGS,
   parameter int REG_ADDR_BITS = DEF_REG_ADDR_BITS,
   parameter int DIGIT         = DEF_DIGIT,
   parameter int NUM_RD        = 2
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              en,
   input  logic [NUM_RD*REG_ADDR_BITS-1:0]   rs_addr,
   output logic [NUM_RD*DIGIT-1:0]           rs_data,
   input  logic [REG_ADDR_BITS-1:0]          rd_addr,
   input  logic                              wr_en,
   input  logic [DIGIT-1:0]                  rd_data,
   output logic [idx_bits(XLEN,DIGIT)-1:0]   digit_idx,
   output logic                              word_start,
   output logic                              word_last
);

   localparam int NDIG = num_digits(XLEN, DIGIT);
   localparam int IDXW = idx_bits(XLEN, DIGIT);

   logic [NUM_REGS-1:1][DIGIT-1:0] reg_dig;
   logic [NUM_REGS-1:1]            wr_sel;
   logic                           wr_go;

   assign wr_go      = en & wr_en;
   assign word_start = (digit_idx == '0);
   assign word_last  = (digit_idx == IDXW'(NDIG-1));

   // Digit position counter, wraps after the last digit of the word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)            digit_idx <= '0;
      else if (en) begin
         if (word_last)   digit_idx <= '0;
         else             digit_idx <= digit_idx + IDXW'(1);
      end
   end

   genvar gi;
   generate
      for (gi = 1; gi < NUM_REGS; gi++) begin : g_reg
         // Out-of-range or zero write addresses never match any register.
         assign wr_sel[gi] = wr_go & (rd_addr == REG_ADDR_BITS'(gi));

         nanov_serial_reg #(.XLEN(XLEN), .DIGIT(DIGIT)) u_reg (
            .clk  (clk),
            .rst  (rst),
            .en   (en),
            .wr   (wr_sel[gi]),
            .wdig (rd_data),
            .q    (reg_dig[gi])
         );
      end

      for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
         logic [REG_ADDR_BITS-1:0] ra;
         logic [DIGIT-1:0]         rv;

         assign ra = rs_addr[gi*REG_ADDR_BITS +: REG_ADDR_BITS];
         assign rs_data[gi*DIGIT +: DIGIT] = rv;

         // Read mux: low digit of the addressed register, zero for x0 / unimplemented.
         always_comb begin
            rv = '0;
            for (int i = 1; i < NUM_REGS; i++)
               if (ra == REG_ADDR_BITS'(i)) rv = reg_dig[i];
`ifdef REGFILE_BYPASS_EN
            for (int i = 1; i < NUM_REGS; i++)
               if (wr_sel[i] && ra == REG_ADDR_BITS'(i)) rv = rd_data;
`endif
         end
      end
   endgenerate

endmodule

// File: tb/tb_nanov_serial_regfile.sv
// Directed bench: XLEN=32, DIGIT=4, NUM_RD=2, NUM_REGS=8 (x8..x15 unimplemented).
module tb_nanov_serial_regfile;

   localparam int XLEN = 32, DIGIT = 4, NUM_RD = 2, NUM_REGS = 8, AB = 4;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic                  en = 1'b0;
   logic [NUM_RD*AB-1:0]  rs_addr = '0;
   logic [NUM_RD*DIGIT-1:0] rs_data;
   logic [AB-1:0]         rd_addr = '0;
   logic                  wr_en = 1'b0;
   logic [DIGIT-1:0]      rd_data = '0;
   logic [2:0]            digit_idx;
   logic                  word_start, word_last;

   int n_chk = 0;
   int n_err = 0;

   nanov_serial_regfile #(
      .XLEN(XLEN), .NUM_REGS(NUM_REGS), .REG_ADDR_BITS(AB), .DIGIT(DIGIT), .NUM_RD(NUM_RD)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .rs_addr(rs_addr), .rs_data(rs_data),
      .rd_addr(rd_addr), .wr_en(wr_en), .rd_data(rd_data),
      .digit_idx(digit_idx), .word_start(word_start), .word_last(word_last)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Write one word LSB digit first; optional same-cycle read of port 0 on the target.
   task automatic write_word(input logic [AB-1:0] a, input logic [31:0] w, input bit chk_byp);
      logic [3:0] d;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         d = w[i*4 +: 4];
         en = 1'b1; wr_en = 1'b1; rd_addr = a; rd_data = d;
         if (chk_byp) begin
            rs_addr = {4'd0, a};
            #1;
`ifdef REGFILE_BYPASS_EN
            chk("byp_rd", 32'(rs_data[3:0]), 32'(d));
`else
            chk("old_rd", 32'(rs_data[3:0]), 32'(0));
`endif
         end
      end
   endtask

   // Read one pass on both ports; optional 3-clock stall at digit 3.
   task automatic read_word(input string tag, input logic [AB-1:0] a, input logic [31:0] w,
                            input bit stall);
      logic [3:0] d;
      for (int i = 0; i < 8; i++) begin
         d = w[i*4 +: 4];
         if (stall && i == 3) begin
            repeat (3) begin
               @(negedge clk);
               en = 1'b0; wr_en = 1'b0; rs_addr = {a, a};
               #1;
               chk("stall_idx", 32'(digit_idx), 32'(3));
               chk("stall_rs", 32'(rs_data[3:0]), 32'(d));
            end
         end
         @(negedge clk);
         en = 1'b1; wr_en = 1'b0; rs_addr = {a, a};
         #1;
         chk({tag, "_idx"}, 32'(digit_idx), 32'(i));
         chk({tag, "_p0"}, 32'(rs_data[3:0]), 32'(d));
         chk({tag, "_p1"}, 32'(rs_data[7:4]), 32'(d));
         if (i == 7) chk({tag, "_last"}, 32'(word_last), 32'(1));
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_idx", 32'(digit_idx), 32'(0));
      chk("rst_start", 32'(word_start), 32'(1));
      chk("rst_last", 32'(word_last), 32'(0));
      for (int a = 0; a < 16; a++) begin
         rs_addr = {4'(a), 4'(a)};
         #1;
         chk("rst_rs", 32'(rs_data), 32'(0));
      end

      write_word(4'd5, 32'hDEADBEEF, 1'b0);
      read_word("x5", 4'd5, 32'hDEADBEEF, 1'b0);

      // Writes to x0 and an unimplemented register are dropped.
      write_word(4'd0, 32'hFFFFFFFF, 1'b0);
      write_word(4'd15, 32'hFFFFFFFF, 1'b0);
      read_word("x0", 4'd0, 32'h0, 1'b0);
      read_word("x15", 4'd15, 32'h0, 1'b0);

      // Stall mid-read, then resume; x5 survived the dropped writes.
      read_word("x5s", 4'd5, 32'hDEADBEEF, 1'b1);

      // Same-cycle read of the register being written.
      write_word(4'd7, 32'h12345678, 1'b1);
      read_word("x7", 4'd7, 32'h12345678, 1'b0);

      // Partial write of x2 cut short by reset at digit 3.
      write_word(4'd2, 32'h00000000, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         en = 1'b1; wr_en = 1'b1; rd_addr = 4'd2; rd_data = 4'(32'hCAFEF00D >> (i*4));
      end
      @(negedge clk);
      chk("pre_rst_idx", 32'(digit_idx), 32'(3));
      rst = 1'b1;
      #1;
      chk("mid_rst_idx", 32'(digit_idx), 32'(0));
      chk("mid_rst_start", 32'(word_start), 32'(1));
      en = 1'b0; wr_en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      read_word("x2", 4'd2, 32'h0, 1'b0);
      read_word("x5r", 4'd5, 32'h0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
